// File: rtl/alu_issue_scheduler.sv
// ALU reservation-station issue scheduler.
// Holds up to DEPTH dispatched ALU micro-ops. It wakes their sources from CDB broadcasts and
// issues the oldest fully-ready entry to the ALU over a valid/ready handshake.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   flush                   mispredict flush; drops every entry, suppresses issue and dispatch
//   disp_*                  dispatch offer (valid/ready) and micro-op payload
//   cdb_valid, cdb_tag      completion broadcast used for source wakeup
//   issue_valid/ready       handshake to the ALU
//   issue_*                 payload of the selected entry (zero when nothing is eligible)
//   occupancy               registered count of valid entries
module alu_issue_scheduler #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 7,
  parameter int unsigned AGE_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [6:0]       disp_opcode,
  input  logic [TAG_W-1:0] disp_prd,
  input  logic [TAG_W-1:0] disp_pr1,
  input  logic             disp_pr1_ready,
  input  logic [TAG_W-1:0] disp_pr2,
  input  logic             disp_pr2_ready,
  input  logic [31:0]      disp_imm,
  input  logic [3:0]       disp_rob_index,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [6:0]       issue_opcode,
  output logic [TAG_W-1:0] issue_prd,
  output logic [TAG_W-1:0] issue_pr1,
  output logic [TAG_W-1:0] issue_pr2,
  output logic [31:0]      issue_imm,
  output logic [3:0]       issue_rob_index,
  output logic [AGE_W:0]   occupancy
);

  localparam int unsigned OccW = AGE_W + 1;
  localparam logic [AGE_W-1:0] AgeMax = AGE_W'(DEPTH - 1);

  typedef struct packed {
    logic [6:0]       opcode;
    logic [TAG_W-1:0] prd;
    logic [TAG_W-1:0] pr1;
    logic [TAG_W-1:0] pr2;
    logic [31:0]      imm;
    logic [3:0]       rob;
  } entry_t;

  entry_t           ent_q     [DEPTH];
  entry_t           ent_d     [DEPTH];
  logic             valid_q   [DEPTH];
  logic             valid_d   [DEPTH];
  logic             pr1_rdy_q [DEPTH];
  logic             pr1_rdy_d [DEPTH];
  logic             pr2_rdy_q [DEPTH];
  logic             pr2_rdy_d [DEPTH];
  logic [AGE_W-1:0] age_q     [DEPTH];
  logic [AGE_W-1:0] age_d     [DEPTH];
  logic [OccW-1:0]  occ_q, occ_d;

  logic             sel_found;
  logic [AGE_W-1:0] sel_idx;
  logic [AGE_W-1:0] sel_age;
  logic             free_found;
  logic [AGE_W-1:0] free_idx;
  logic             disp_fire;
  logic             issue_fire;
  logic             wr_pr1_rdy;
  logic             wr_pr2_rdy;
  entry_t           sel_ent;

  // Oldest eligible entry wins; strict compare keeps the lower index on a saturated-age tie.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && pr1_rdy_q[i] && pr2_rdy_q[i] && (!sel_found || age_q[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = AGE_W'(i);
        sel_age   = age_q[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = AGE_W'(i);
      end
    end
  end

  assign disp_ready  = occ_q < OccW'(DEPTH);
  assign issue_valid = sel_found && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign disp_fire   = disp_valid && disp_ready && free_found && !flush;
  assign occupancy   = occ_q;

  // Write-time bypass: x0 and a same-cycle broadcast both count as ready.
  assign wr_pr1_rdy = disp_pr1_ready || (disp_pr1 == '0) || (cdb_valid && (cdb_tag == disp_pr1));
  assign wr_pr2_rdy = disp_pr2_ready || (disp_pr2 == '0) || (cdb_valid && (cdb_tag == disp_pr2));

  assign sel_ent         = sel_found ? ent_q[sel_idx] : '0;
  assign issue_opcode    = sel_ent.opcode;
  assign issue_prd       = sel_ent.prd;
  assign issue_pr1       = sel_ent.pr1;
  assign issue_pr2       = sel_ent.pr2;
  assign issue_imm       = sel_ent.imm;
  assign issue_rob_index = sel_ent.rob;

  always_comb begin
    ent_d     = ent_q;
    valid_d   = valid_q;
    pr1_rdy_d = pr1_rdy_q;
    pr2_rdy_d = pr2_rdy_q;
    age_d     = age_q;
    occ_d     = occ_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = 1'b0;
        age_d[i]   = '0;
      end
      occ_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && valid_q[i]) begin
          if (ent_q[i].pr1 == cdb_tag) pr1_rdy_d[i] = 1'b1;
          if (ent_q[i].pr2 == cdb_tag) pr2_rdy_d[i] = 1'b1;
        end
        // Age only advances on dispatch, so relative order among survivors never changes.
        if (disp_fire && valid_q[i] && !(issue_fire && sel_idx == AGE_W'(i))
            && age_q[i] != AgeMax) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
      if (issue_fire) valid_d[sel_idx] = 1'b0;
      // free_idx comes from registered valids, so a slot freed this cycle is never reused.
      if (disp_fire) begin
        valid_d[free_idx]   = 1'b1;
        age_d[free_idx]     = '0;
        pr1_rdy_d[free_idx] = wr_pr1_rdy;
        pr2_rdy_d[free_idx] = wr_pr2_rdy;
        ent_d[free_idx]     = '{opcode: disp_opcode, prd: disp_prd, pr1: disp_pr1,
                                pr2: disp_pr2, imm: disp_imm, rob: disp_rob_index};
      end
      unique case ({disp_fire, issue_fire})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]     <= '0;
        valid_q[i]   <= 1'b0;
        pr1_rdy_q[i] <= 1'b0;
        pr2_rdy_q[i] <= 1'b0;
        age_q[i]     <= '0;
      end
      occ_q <= '0;
    end else begin
      ent_q     <= ent_d;
      valid_q   <= valid_d;
      pr1_rdy_q <= pr1_rdy_d;
      pr2_rdy_q <= pr2_rdy_d;
      age_q     <= age_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: directed dispatch/CDB/flush sequences, with
// expected issue payloads queued in issue order and checked by a negedge monitor.
module tb_alu_issue_scheduler;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 7;
  localparam int unsigned AGE_W = 3;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic             disp_valid, disp_ready;
  logic [6:0]       disp_opcode;
  logic [TAG_W-1:0] disp_prd, disp_pr1, disp_pr2;
  logic             disp_pr1_ready, disp_pr2_ready;
  logic [31:0]      disp_imm;
  logic [3:0]       disp_rob_index;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic             issue_valid, issue_ready;
  logic [6:0]       issue_opcode;
  logic [TAG_W-1:0] issue_prd, issue_pr1, issue_pr2;
  logic [31:0]      issue_imm;
  logic [3:0]       issue_rob_index;
  logic [AGE_W:0]   occupancy;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  alu_issue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .AGE_W(AGE_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_prd(disp_prd), .disp_pr1(disp_pr1), .disp_pr1_ready(disp_pr1_ready),
    .disp_pr2(disp_pr2), .disp_pr2_ready(disp_pr2_ready), .disp_imm(disp_imm),
    .disp_rob_index(disp_rob_index), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
    .issue_prd(issue_prd), .issue_pr1(issue_pr1), .issue_pr2(issue_pr2),
    .issue_imm(issue_imm), .issue_rob_index(issue_rob_index), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] opc_of(input int rob);
    return {3'b011, 4'(rob)};
  endfunction

  function automatic logic [31:0] imm_of(input int rob);
    return {28'hABCD000, 4'(rob)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input int rob, input int prd, input int pr1, input int pr2);
    exp_q.push_back({opc_of(rob), 7'(prd), 7'(pr1), 7'(pr2), imm_of(rob), 4'(rob)});
  endtask

  task automatic set_op(input int rob, input int prd, input int pr1, input bit r1,
                        input int pr2, input bit r2);
    disp_opcode    = opc_of(rob);
    disp_imm       = imm_of(rob);
    disp_rob_index = 4'(rob);
    disp_prd       = 7'(prd);
    disp_pr1       = 7'(pr1);
    disp_pr1_ready = r1;
    disp_pr2       = 7'(pr2);
    disp_pr2_ready = r2;
  endtask

  task automatic dispatch(input int rob, input int prd, input int pr1, input bit r1,
                          input int pr2, input bit r2);
    set_op(rob, prd, pr1, r1, pr2, r2);
    disp_valid = 1'b1;
    check("disp_ready_before_dispatch", 64'(disp_ready), 64'd1);
    step();
    disp_valid = 1'b0;
  endtask

  task automatic cdb(input int tag);
    cdb_valid = 1'b1;
    cdb_tag   = 7'(tag);
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0;
    set_op(0, 0, 0, 1'b0, 0, 1'b0);

    fork
      forever begin
        @(negedge clk);
        if (issue_valid && issue_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got rob %0d expected no issue", issue_rob_index);
          end else begin
            check("issue_payload", {issue_opcode, issue_prd, issue_pr1, issue_pr2, issue_imm,
                                    issue_rob_index}, exp_q.pop_front());
          end
        end
      end
      begin
        #500000;
        $display("FAIL timeout: got no finish expected finish within time limit");
        $fatal(1);
      end
    join_none

    // Reset, then a single ready op
    step(); step();
    reset = 1'b0;
    check("reset_disp_ready", 64'(disp_ready), 64'd1);
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_occupancy", 64'(occupancy), 64'd0);
    check("reset_payload", {issue_opcode, issue_prd, issue_pr1, issue_pr2, issue_imm,
                            issue_rob_index}, 64'd0);
    issue_ready = 1'b1;
    expect_issue(1, 10, 3, 4);
    dispatch(1, 10, 3, 1'b1, 4, 1'b1);
    check("t1_occ_after_dispatch", 64'(occupancy), 64'd1);
    check("t1_issue_valid", 64'(issue_valid), 64'd1);
    check("t1_issue_prd", 64'(issue_prd), 64'd10);
    step();
    check("t1_occ_after_issue", 64'(occupancy), 64'd0);
    check("t1_idle", 64'(issue_valid), 64'd0);

    // Wakeup ordering: younger ready B before older waiting A
    dispatch(2, 21, 20, 1'b0, 5, 1'b1);
    check("t2_a_not_eligible", 64'(issue_valid), 64'd0);
    expect_issue(3, 22, 6, 7);
    expect_issue(2, 21, 20, 5);
    dispatch(3, 22, 6, 1'b1, 7, 1'b1);
    check("t2_b_first", 64'(issue_rob_index), 64'd3);
    cdb(20);
    check("t2_a_valid_after_cdb", 64'(issue_valid), 64'd1);
    check("t2_a_rob_after_cdb", 64'(issue_rob_index), 64'd2);
    step();
    check("t2_occ_empty", 64'(occupancy), 64'd0);

    // Age priority with a stalled ALU
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_issue(k, 40 + k, 1, 2);
      dispatch(k, 40 + k, 1, 1'b1, 2, 1'b1);
    end
    check("t3_occ4", 64'(occupancy), 64'd4);
    step();
    check("t3_held_rob0", 64'(issue_rob_index), 64'd0);
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_order", 64'(issue_rob_index), 64'(k));
      step();
    end
    check("t3_occ_empty", 64'(occupancy), 64'd0);

    // Full, then mass wakeup
    for (int k = 0; k < 8; k++) begin
      expect_issue(4 + k, 50 + k, 30, 0);
      dispatch(4 + k, 50 + k, 30, 1'b0, 0, 1'b1);
    end
    check("t4_occ_full", 64'(occupancy), 64'd8);
    check("t4_disp_ready_full", 64'(disp_ready), 64'd0);
    check("t4_none_eligible", 64'(issue_valid), 64'd0);
    set_op(15, 99, 0, 1'b1, 0, 1'b1);
    disp_valid = 1'b1;
    step();
    disp_valid = 1'b0;
    check("t4_ninth_rejected", 64'(occupancy), 64'd8);
    cdb(30);
    for (int k = 0; k < 8; k++) begin
      check("t4_drain_valid", 64'(issue_valid), 64'd1);
      check("t4_drain_order", 64'(issue_rob_index), 64'(4 + k));
      step();
    end
    check("t4_occ_drained", 64'(occupancy), 64'd0);

    // Same-cycle CDB bypass on pr1, and x0 on pr2 with ready flag low
    issue_ready = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag = 7'd31;
    expect_issue(12, 60, 31, 0);
    dispatch(12, 60, 31, 1'b0, 0, 1'b0);
    cdb_valid = 1'b0;
    check("t4_bypass_ready", 64'(issue_valid), 64'd1);
    issue_ready = 1'b1;
    step();
    check("t4_bypass_issued", 64'(occupancy), 64'd0);

    // Flush with dispatch in the same cycle
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) dispatch(k, 70 + k, 50, 1'b0, 0, 1'b1);
    dispatch(3, 73, 1, 1'b1, 2, 1'b1);
    dispatch(4, 74, 1, 1'b1, 2, 1'b1);
    check("t5_occ5", 64'(occupancy), 64'd5);
    check("t5_eligible", 64'(issue_valid), 64'd1);
    set_op(9, 79, 1, 1'b1, 2, 1'b1);
    flush = 1'b1;
    disp_valid = 1'b1;
    issue_ready = 1'b1;
    #1;
    check("t5_flush_blocks_issue", 64'(issue_valid), 64'd0);
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    check("t5_occ_after_flush", 64'(occupancy), 64'd0);
    check("t5_disp_ready_after_flush", 64'(disp_ready), 64'd1);
    check("t5_dispatch_dropped", 64'(issue_valid), 64'd0);
    cdb(50);
    check("t5_no_ghost_wakeup", 64'(issue_valid), 64'd0);

    // Reset while issuing
    issue_ready = 1'b0;
    for (int k = 5; k < 8; k++) dispatch(k, 80 + k, 1, 1'b1, 2, 1'b1);
    expect_issue(5, 85, 1, 2);
    issue_ready = 1'b1;
    step();
    reset = 1'b1;
    issue_ready = 1'b0;
    step();
    reset = 1'b0;
    check("t5_reset_occ", 64'(occupancy), 64'd0);
    check("t5_reset_issue_valid", 64'(issue_valid), 64'd0);
    check("t5_reset_disp_ready", 64'(disp_ready), 64'd1);
    check("t5_reset_payload", 64'(issue_prd), 64'd0);

    // Dispatch and issue together at occupancy 7
    expect_issue(0, 90, 1, 2);
    for (int k = 1; k < 7; k++) expect_issue(k, 90 + k, 60, 2);
    expect_issue(7, 97, 3, 4);
    dispatch(0, 90, 1, 1'b1, 2, 1'b1);
    for (int k = 1; k < 7; k++) dispatch(k, 90 + k, 60, 1'b0, 2, 1'b1);
    check("t6_occ7", 64'(occupancy), 64'd7);
    issue_ready = 1'b1;
    dispatch(7, 97, 3, 1'b1, 4, 1'b1);
    issue_ready = 1'b0;
    check("t6_occ_stays7", 64'(occupancy), 64'd7);
    check("t6_disp_ready_stays1", 64'(disp_ready), 64'd1);
    check("t6_new_entry_rob", 64'(issue_rob_index), 64'd7);
    cdb(60);
    check("t6_older_wins", 64'(issue_rob_index), 64'd1);
    issue_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      check("t6_order", 64'(issue_rob_index), 64'(k));
      step();
    end
    check("t6_occ_empty", 64'(occupancy), 64'd0);

    step(); step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- Issue scheduler for the ALU reservation station. Holds up to DEPTH dispatched ALU micro-ops with physical source tags and ready bits.
- Wakes sources on completion broadcasts from the common data bus (CDB).
- Each cycle, selects the oldest entry with both sources ready and hands it to the ALU over a valid/ready handshake.
- Sits between the dispatch stage and the ALU functional unit. Its entry payload matches the alu_rs_data fields.

Parameters:
- DEPTH, 8, number of RS entries; must be a power of 2, max 8.
- TAG_W, 7, physical register tag width.
- AGE_W, 3, age field width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; drops all entries.
- disp_valid  in  1  dispatch offers an op.
- disp_ready  out  1  an entry is free.
- disp_opcode  in  7  opcode.
- disp_prd  in  TAG_W  destination physical register.
- disp_pr1  in  TAG_W  source 1 tag.
- disp_pr1_ready  in  1  source 1 ready at dispatch.
- disp_pr2  in  TAG_W  source 2 tag.
- disp_pr2_ready  in  1  source 2 ready at dispatch.
- disp_imm  in  32  immediate.
- disp_rob_index  in  4  ROB index.
- cdb_valid  in  1  completion broadcast valid.
- cdb_tag  in  TAG_W  completed physical register.
- issue_valid  out  1  selected entry is ready to issue.
- issue_ready  in  1  ALU accepts.
- issue_opcode, issue_prd, issue_pr1, issue_pr2, issue_imm, issue_rob_index  out  7/TAG_W/TAG_W/TAG_W/32/4  selected entry payload.
- occupancy  out  AGE_W+1  number of valid entries.

Behaviour:
- **State:** per entry, {valid, opcode, prd, pr1, pr1_ready, pr2, pr2_ready, imm, rob_index, age}. All sequential updates occur on posedge clk.
- **Reset:** all valid=0 and all ages=0 next cycle.
  - Outputs after reset: disp_ready=1, issue_valid=0, occupancy=0, issue_* payload=0 (payload is a don't-care when issue_valid=0, but must be driven 0).
- **Precedence:** reset > flush > normal operation.
- **Flush:** same as reset for valid bits. issue_valid forced 0 combinationally while flush=1. Dispatch is ignored that cycle even if disp_valid & disp_ready.
- **disp_ready:** equals (occupancy < DEPTH). It is combinational from registered state and does not credit a same-cycle issue.
- **Dispatch accept (disp_valid & disp_ready):**
  - Written to the lowest-index free entry with age=0.
  - Every other valid entry that is not issuing this cycle has age incremented, saturating at DEPTH-1.
  - This keeps ages unique: larger age means older.
- **Source ready at write:** pr1_ready = disp_pr1_ready OR (disp_pr1 == 0) OR (cdb_valid & cdb_tag == disp_pr1). pr2 uses the same rule. Tag 0 (x0) is always ready.
- **Wakeup:** when cdb_valid, every valid entry with pr1 == cdb_tag sets pr1_ready, and likewise for pr2. The entry becomes issue-eligible the next cycle; there is no same-cycle wake-and-issue.
- **Selection (combinational from registered state):**
  - eligible = valid & pr1_ready & pr2_ready.
  - Select the eligible entry with maximum age.
  - issue_valid = any eligible & !flush.
  - Payload is driven from the selected entry.
- **Issue handshake:**
  - On issue_valid & issue_ready, the selected entry's valid clears next cycle.
  - If issue_ready=0, the selection may change only when an older entry becomes eligible. The held entry is never dropped.
- **Simultaneous dispatch + issue:** both take effect. The freed slot is not reused in the same cycle. occupancy is unchanged.
- **Simultaneous CDB + dispatch** to a matching tag: handled by the write-time bypass above.
- **occupancy:** registered count of valid entries, updated +1 per dispatch and -1 per issue. It is 0 after flush or reset.
- **Latency:** dispatch to earliest issue is 1 cycle, when sources are ready at dispatch.

Test Plan:
1. **Reset, then dispatch with ready sources:** reset 2 cycles, then dispatch {prd=10, pr1=3 ready, pr2=4 ready, rob=1} with issue_ready=1 → issue_valid=1 the following cycle with issue_prd=10, rob=1; occupancy 0→1→0.
2. **Wakeup ordering:**
   - Dispatch A (pr1=20 not ready, rob=2), then B (both ready, rob=3).
   - Expect: B issues first.
   - Then cdb_tag=20 → A issues exactly 1 cycle after the broadcast.
3. **Age priority:**
   - Hold issue_ready=0, dispatch rob 0..3, all ready.
   - Raise issue_ready → issue order is rob 0,1,2,3 on consecutive cycles.
4. **Full and bypass:**
   - Fill 8 entries, all pr1=30 not ready → disp_ready=0, occupancy=8; a 9th disp_valid is not accepted.
   - cdb_tag=30 → issue begins next cycle, one per cycle.
   - Dispatching pr1=31 while cdb_tag=31 in the same cycle → entry is ready at write.
5. **Flush mid-operation:**
   - With 5 entries (2 eligible) and flush=1 together with disp_valid=1 → issue_valid=0 that cycle.
   - Next cycle: occupancy=0, disp_ready=1, the dispatched op is absent.
   - Reset asserted mid-issue behaves the same.
6. **Simultaneous dispatch + issue at occupancy 7:** occupancy stays 7, disp_ready stays 1, and the new entry is written to the lowest free index with age 0.
